mock_bus_n: RTL and testbench
=============================

// Module: mock_bus_n
//
// PURPOSE
//   Parametrised simulation bus resolver for the EconoPET system bench. Merges NUM_DRIVERS
//   tri-state initiators (FPGA top, mock CPU, RAM, IO, ...) onto one shared address/data/we_n
//   bus. Provides per-group bus-keeper decay, contention detection, a saturating contention
//   counter and first-fault capture for assertions.
//   Sits between the mock_* models and top inside the system bench.
//
// PARAMETERS
//   NUM_DRIVERS  4    number of bus initiators (>=2)
//   ADDR_WIDTH   16   address bus width (CPU_ADDR_WIDTH)
//   DATA_WIDTH   8    data bus width
//   HOLD_CYCLES  4    cycles a released group keeps its last value before floating (0 allowed)
//   ADDR_PULL    '1   address value when floating
//   DATA_PULL    '1   data value when floating
//   CNT_WIDTH    16   contention counter width
//
// PORTS
//   clock_i            in   1                 system clock
//   reset_i            in   1                 async, active-high reset
//   drv_addr_i         in   NUM_DRIVERS*AW    packed driver addresses; driver k at [k*AW +: AW]
//   drv_addr_oe_i      in   NUM_DRIVERS       address output enables
//   drv_data_i         in   NUM_DRIVERS*DW    packed driver data
//   drv_data_oe_i      in   NUM_DRIVERS       data output enables
//   drv_we_n_i         in   NUM_DRIVERS       driver we_n
//   drv_we_n_oe_i      in   NUM_DRIVERS       we_n output enables
//   clear_i            in   1                 sync clear of counter and capture
//   bus_addr_o         out  ADDR_WIDTH        resolved address
//   bus_data_o         out  DATA_WIDTH        resolved data
//   bus_we_n_o         out  1                 resolved we_n (pull value 1)
//   bus_data_valid_o   out  1                 data is driven or held (not floating)
//   contention_o       out  1                 1-cycle pulse: any group had >1 enable
//   contention_count_o out  CNT_WIDTH         saturating count of contention cycles
//   first_valid_o      out  1                 first-fault capture registers hold data
//   first_group_o      out  3                 {we_n,data,addr} groups in contention at capture
//   first_oe_o         out  NUM_DRIVERS       drv_data_oe_i | drv_addr_oe_i at capture
//   first_addr_o       out  ADDR_WIDTH        resolved address at capture
//
// BEHAVIOUR
//   - Latency: all outputs registered; inputs at edge t appear after edge t+1.
//   - Reset: groups in FLOAT; addr=ADDR_PULL, data=DATA_PULL, we_n=1, data_valid=0,
//     contention=0, count=0, first_*=0.
//   - Each group (addr, data, we_n) runs an independent keeper FSM. The enable count n is
//     the popcount of that group's oe vector:
//     - DRIVEN (n>=1): output the resolved value. n==1 selects that driver. n>1 outputs the
//       bitwise AND of the enabled drivers, modelling wired-low dominance. Stay in DRIVEN
//       while n>=1.
//     - n==0 from DRIVEN: go to HOLD, load hold counter = HOLD_CYCLES, output the last value.
//       With HOLD_CYCLES==0, go straight to FLOAT.
//     - HOLD: decrement each cycle while n==0. At 0, go to FLOAT. n>=1 returns to DRIVEN
//       immediately, from HOLD or FLOAT.
//     - FLOAT: output the pull value.
//     - Release at edge t: held value visible on edges t+1..t+HOLD_CYCLES; pull value
//       from t+HOLD_CYCLES+1.
//   - bus_data_valid_o = data FSM state != FLOAT.
//   - contention_o is asserted for the registered cycle following any group with n>1.
//   - Counter increments per contention cycle and saturates at all-ones (never wraps).
//   - First capture:
//     - Captures on the first contention cycle while first_valid_o==0.
//     - Later contention does not overwrite it.
//   - clear_i:
//     - Zeroes the count and first_* on the next edge.
//     - If contention occurs in the same cycle as clear_i, it is counted and captured
//       after the clear: count=1, first_valid=1.
//   - Reset mid-HOLD or mid-contention returns everything to reset values asynchronously.
//   - X/Z on an enable is a bench error; flagged with `assert in sim only.
//
// TESTING
//   1. Reset, no enables -> addr=16'hFFFF, data=8'hFF, we_n=1, data_valid=0, count=0.
//   2. Driver 1 drives data 8'hA5 for 3 cycles, then releases (HOLD_CYCLES=4)
//      -> 8'hA5 for 4 cycles after release, then 8'hFF; data_valid falls the same edge.
//   3. Drivers 0,2 both enable data with 8'hF0 and 8'h3C at addr 16'hE810
//      -> data=8'h30, contention_o pulse, count=1, first_group=3'b010, first_addr=16'hE810.
//   4. Second contention on addr -> count=2; first_* unchanged; clear_i with concurrent
//      contention -> count=1, first_group reflects the new event.
//   5. CNT_WIDTH=2, 5 contention cycles -> count sticks at 2'b11.
//   6. HOLD_CYCLES=0, NUM_DRIVERS=6: release -> pull value on the next edge.
//      Reset asserted mid-HOLD -> immediate FLOAT values.

Source files
------------

// File: rtl/mock_bus_n_if.sv
// Shared bus bundle between the mock_* initiators and the resolver.
// Ports (by modport):
//   master : drives drv_* and clear_i, observes the resolved bus and fault capture
//   slave  : the resolver; consumes drv_* and clear_i, produces bus_*/contention/first_*
// Parameters must match those of the mock_bus_n instance the bundle is bound to.
interface mock_bus_n_if #(
    parameter int unsigned NUM_DRIVERS = 4,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH   = 16
);
    logic [NUM_DRIVERS*ADDR_WIDTH-1:0] drv_addr_i;
    logic [NUM_DRIVERS-1:0]            drv_addr_oe_i;
    logic [NUM_DRIVERS*DATA_WIDTH-1:0] drv_data_i;
    logic [NUM_DRIVERS-1:0]            drv_data_oe_i;
    logic [NUM_DRIVERS-1:0]            drv_we_n_i;
    logic [NUM_DRIVERS-1:0]            drv_we_n_oe_i;
    logic                              clear_i;
    logic [ADDR_WIDTH-1:0]             bus_addr_o;
    logic [DATA_WIDTH-1:0]             bus_data_o;
    logic                              bus_we_n_o;
    logic                              bus_data_valid_o;
    logic                              contention_o;
    logic [CNT_WIDTH-1:0]              contention_count_o;
    logic                              first_valid_o;
    logic [2:0]                        first_group_o;
    logic [NUM_DRIVERS-1:0]            first_oe_o;
    logic [ADDR_WIDTH-1:0]             first_addr_o;

    modport master (
        output drv_addr_i, drv_addr_oe_i, drv_data_i, drv_data_oe_i,
               drv_we_n_i, drv_we_n_oe_i, clear_i,
        input  bus_addr_o, bus_data_o, bus_we_n_o, bus_data_valid_o,
               contention_o, contention_count_o, first_valid_o,
               first_group_o, first_oe_o, first_addr_o
    );

    modport slave (
        input  drv_addr_i, drv_addr_oe_i, drv_data_i, drv_data_oe_i,
               drv_we_n_i, drv_we_n_oe_i, clear_i,
        output bus_addr_o, bus_data_o, bus_we_n_o, bus_data_valid_o,
               contention_o, contention_count_o, first_valid_o,
               first_group_o, first_oe_o, first_addr_o
    );
endinterface

// File: rtl/mock_bus_n.sv
// Simulation bus resolver: merges NUM_DRIVERS tri-state initiators onto one
// address/data/we_n bus with per-group keeper decay, wired-AND contention
// resolution, a saturating contention counter and first-fault capture.
// Ports:
//   clock_i  in  system clock
//   reset_i  in  async active-high reset
//   bus      mock_bus_n_if.slave: drv_* inputs, clear_i, resolved bus_*,
//            contention pulse/count and first_* capture (all registered)

// One bus group: resolves enabled drivers and decays DRIVEN -> HOLD -> FLOAT.
module mock_bus_n_keeper #(
    parameter int unsigned     NUM_DRIVERS = 4,
    parameter int unsigned     WIDTH       = 8,
    parameter int unsigned     HOLD_CYCLES = 4,
    parameter logic [WIDTH-1:0] PULL       = '1
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic [NUM_DRIVERS*WIDTH-1:0] drv_i,
    input  logic [NUM_DRIVERS-1:0]       oe_i,
    output logic [WIDTH-1:0]             value_o,
    output logic [WIDTH-1:0]             value_c,
    output logic                         valid_o,
    output logic                         multi_c
);
    localparam int unsigned CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    typedef enum logic [1:0] {ST_FLOAT, ST_HOLD, ST_DRIVEN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] resolved;
    logic             any_c;

    // Wired-low dominance: AND of all enabled drivers (single driver passes through).
    always_comb begin
        resolved = '1;
        for (int k = 0; k < NUM_DRIVERS; k++) begin
            if (oe_i[k]) resolved = resolved & drv_i[k*WIDTH +: WIDTH];
        end
    end

    assign any_c   = |oe_i;
    // More than one bit set iff clearing the lowest set bit leaves something.
    assign multi_c = |(oe_i & (oe_i - NUM_DRIVERS'(1)));

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_FLOAT;
            cnt_q   <= '0;
            value_o <= PULL;
            valid_o <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            value_o <= value_c;
            valid_o <= (state_d != ST_FLOAT);
        end
    end

    // Next state / next value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        value_c = value_o;
        if (any_c) begin
            state_d = ST_DRIVEN;
            cnt_d   = '0;
            value_c = resolved;
        end else begin
            case (state_q)
                ST_DRIVEN: begin
                    if (HOLD_CYCLES == 0) begin
                        state_d = ST_FLOAT;
                        value_c = PULL;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = CW'(HOLD_CYCLES);
                    end
                end
                ST_HOLD: begin
                    // cnt_q==1 here is the last held cycle; next edge floats.
                    if (cnt_q <= CW'(1)) begin
                        state_d = ST_FLOAT;
                        cnt_d   = '0;
                        value_c = PULL;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = ST_FLOAT;
                    value_c = PULL;
                end
            endcase
        end
    end
endmodule

module mock_bus_n #(
    parameter int unsigned          NUM_DRIVERS = 4,
    parameter int unsigned          ADDR_WIDTH  = 16,
    parameter int unsigned          DATA_WIDTH  = 8,
    parameter int unsigned          HOLD_CYCLES = 4,
    parameter logic [ADDR_WIDTH-1:0] ADDR_PULL  = '1,
    parameter logic [DATA_WIDTH-1:0] DATA_PULL  = '1,
    parameter int unsigned          CNT_WIDTH   = 16
) (
    input  logic         clock_i,
    input  logic         reset_i,
    mock_bus_n_if.slave  bus
);
    logic [ADDR_WIDTH-1:0]  addr_q, addr_next;
    logic [DATA_WIDTH-1:0]  data_q, data_next;
    logic                   we_n_q, we_n_next;
    logic                   addr_valid, data_valid, we_valid;
    logic                   addr_multi, data_multi, we_multi;
    logic                   contention_c;
    logic [2:0]             group_c;
    logic                   contention_q;
    logic [CNT_WIDTH-1:0]   count_q;
    logic                   first_valid_q;
    logic [2:0]             first_group_q;
    logic [NUM_DRIVERS-1:0] first_oe_q;
    logic [ADDR_WIDTH-1:0]  first_addr_q;
    logic                   unused_keeper;

    mock_bus_n_keeper #(
        .NUM_DRIVERS(NUM_DRIVERS), .WIDTH(ADDR_WIDTH),
        .HOLD_CYCLES(HOLD_CYCLES), .PULL(ADDR_PULL)
    ) u_addr (
        .clock_i(clock_i), .reset_i(reset_i),
        .drv_i(bus.drv_addr_i), .oe_i(bus.drv_addr_oe_i),
        .value_o(addr_q), .value_c(addr_next), .valid_o(addr_valid), .multi_c(addr_multi)
    );

    mock_bus_n_keeper #(
        .NUM_DRIVERS(NUM_DRIVERS), .WIDTH(DATA_WIDTH),
        .HOLD_CYCLES(HOLD_CYCLES), .PULL(DATA_PULL)
    ) u_data (
        .clock_i(clock_i), .reset_i(reset_i),
        .drv_i(bus.drv_data_i), .oe_i(bus.drv_data_oe_i),
        .value_o(data_q), .value_c(data_next), .valid_o(data_valid), .multi_c(data_multi)
    );

    mock_bus_n_keeper #(
        .NUM_DRIVERS(NUM_DRIVERS), .WIDTH(1),
        .HOLD_CYCLES(HOLD_CYCLES), .PULL(1'b1)
    ) u_we_n (
        .clock_i(clock_i), .reset_i(reset_i),
        .drv_i(bus.drv_we_n_i), .oe_i(bus.drv_we_n_oe_i),
        .value_o(we_n_q), .value_c(we_n_next), .valid_o(we_valid), .multi_c(we_multi)
    );

    assign unused_keeper = ^{addr_valid, we_valid, data_next, we_n_next};

    assign group_c      = {we_multi, data_multi, addr_multi};
    assign contention_c = |group_c;

    // Contention pulse, saturating counter and first-fault capture; clear wins
    // over history but a same-cycle contention is still recorded after it.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            contention_q  <= 1'b0;
            count_q       <= '0;
            first_valid_q <= 1'b0;
            first_group_q <= '0;
            first_oe_q    <= '0;
            first_addr_q  <= '0;
        end else begin
            contention_q <= contention_c;
            if (bus.clear_i) begin
                count_q <= contention_c ? CNT_WIDTH'(1) : '0;
            end else if (contention_c && (count_q != '1)) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end
            if (contention_c && (bus.clear_i || !first_valid_q)) begin
                first_valid_q <= 1'b1;
                first_group_q <= group_c;
                first_oe_q    <= bus.drv_data_oe_i | bus.drv_addr_oe_i;
                first_addr_q  <= addr_next;
            end else if (bus.clear_i) begin
                first_valid_q <= 1'b0;
                first_group_q <= '0;
                first_oe_q    <= '0;
                first_addr_q  <= '0;
            end
        end
    end

    assign bus.bus_addr_o         = addr_q;
    assign bus.bus_data_o         = data_q;
    assign bus.bus_we_n_o         = we_n_q;
    assign bus.bus_data_valid_o   = data_valid;
    assign bus.contention_o       = contention_q;
    assign bus.contention_count_o = count_q;
    assign bus.first_valid_o      = first_valid_q;
    assign bus.first_group_o      = first_group_q;
    assign bus.first_oe_o         = first_oe_q;
    assign bus.first_addr_o       = first_addr_q;

`ifndef SYNTHESIS
    // Undriven enables are a bench wiring error, not a bus state.
    always @(posedge clock_i) begin
        if (!reset_i) begin
            assert (!$isunknown({bus.drv_addr_oe_i, bus.drv_data_oe_i, bus.drv_we_n_oe_i}))
                else $error("mock_bus_n: X/Z on a driver output enable");
        end
    end
`endif
endmodule

// File: tb/tb_mock_bus_n.sv
// Directed bench for mock_bus_n: a default instance (4 drivers, HOLD 4,
// 16-bit counter) and a small instance (6 drivers, HOLD 0, 2-bit counter).
module tb_mock_bus_n;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mock_bus_n_if #(.NUM_DRIVERS(4), .ADDR_WIDTH(16), .DATA_WIDTH(8), .CNT_WIDTH(16)) bus_a ();
    mock_bus_n_if #(.NUM_DRIVERS(6), .ADDR_WIDTH(16), .DATA_WIDTH(8), .CNT_WIDTH(2))  bus_b ();

    mock_bus_n #(
        .NUM_DRIVERS(4), .ADDR_WIDTH(16), .DATA_WIDTH(8),
        .HOLD_CYCLES(4), .CNT_WIDTH(16)
    ) dut_a (
        .clock_i(clk), .reset_i(rst), .bus(bus_a)
    );

    mock_bus_n #(
        .NUM_DRIVERS(6), .ADDR_WIDTH(16), .DATA_WIDTH(8),
        .HOLD_CYCLES(0), .CNT_WIDTH(2)
    ) dut_b (
        .clock_i(clk), .reset_i(rst), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: inputs set before the posedge, outputs sampled on the following negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus_a.drv_addr_i = '0; bus_a.drv_addr_oe_i = '0;
        bus_a.drv_data_i = '0; bus_a.drv_data_oe_i = '0;
        bus_a.drv_we_n_i = '0; bus_a.drv_we_n_oe_i = '0;
        bus_a.clear_i    = 1'b0;
        bus_b.drv_addr_i = '0; bus_b.drv_addr_oe_i = '0;
        bus_b.drv_data_i = '0; bus_b.drv_data_oe_i = '0;
        bus_b.drv_we_n_i = '0; bus_b.drv_we_n_oe_i = '0;
        bus_b.clear_i    = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_addr",  32'(bus_a.bus_addr_o), 32'hFFFF);
        check("rst_data",  32'(bus_a.bus_data_o), 32'hFF);
        check("rst_we_n",  32'(bus_a.bus_we_n_o), 32'h1);
        check("rst_valid", 32'(bus_a.bus_data_valid_o), 32'h0);
        check("rst_count", 32'(bus_a.contention_count_o), 32'h0);
        check("rst_first", 32'(bus_a.first_valid_o), 32'h0);
        rst = 1'b0;
        step();
        check("idle_data", 32'(bus_a.bus_data_o), 32'hFF);

        // Single driver, then keeper decay over four held cycles
        bus_a.drv_data_i    = {8'h00, 8'h00, 8'hA5, 8'h00};
        bus_a.drv_data_oe_i = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            check("drive_data",  32'(bus_a.bus_data_o), 32'hA5);
            check("drive_valid", 32'(bus_a.bus_data_valid_o), 32'h1);
        end
        bus_a.drv_data_oe_i = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step();
            check("hold_data",  32'(bus_a.bus_data_o), 32'hA5);
            check("hold_valid", 32'(bus_a.bus_data_valid_o), 32'h1);
        end
        step();
        check("float_data",  32'(bus_a.bus_data_o), 32'hFF);
        check("float_valid", 32'(bus_a.bus_data_valid_o), 32'h0);

        // Data contention: F0 & 3C = 30, address E810 from driver 0
        bus_a.drv_addr_i    = {16'h0000, 16'h0000, 16'h0000, 16'hE810};
        bus_a.drv_addr_oe_i = 4'b0001;
        bus_a.drv_data_i    = {8'h00, 8'h3C, 8'h00, 8'hF0};
        bus_a.drv_data_oe_i = 4'b0101;
        step();
        check("cont_data",   32'(bus_a.bus_data_o), 32'h30);
        check("cont_addr",   32'(bus_a.bus_addr_o), 32'hE810);
        check("cont_pulse",  32'(bus_a.contention_o), 32'h1);
        check("cont_count",  32'(bus_a.contention_count_o), 32'h1);
        check("first_valid", 32'(bus_a.first_valid_o), 32'h1);
        check("first_group", 32'(bus_a.first_group_o), 32'h2);
        check("first_addr",  32'(bus_a.first_addr_o), 32'hE810);
        check("first_oe",    32'(bus_a.first_oe_o), 32'h5);
        bus_a.drv_addr_oe_i = 4'b0000;
        bus_a.drv_data_oe_i = 4'b0000;
        step();
        check("pulse_end",   32'(bus_a.contention_o), 32'h0);
        check("count_kept",  32'(bus_a.contention_count_o), 32'h1);

        // Second contention on address: 1234 & 00FF = 0034, capture unchanged
        bus_a.drv_addr_i    = {16'h00FF, 16'h0000, 16'h1234, 16'h0000};
        bus_a.drv_addr_oe_i = 4'b1010;
        step();
        check("addr_and",     32'(bus_a.bus_addr_o), 32'h0034);
        check("count_two",    32'(bus_a.contention_count_o), 32'h2);
        check("first_group2", 32'(bus_a.first_group_o), 32'h2);
        check("first_addr2",  32'(bus_a.first_addr_o), 32'hE810);
        bus_a.drv_addr_oe_i = 4'b0000;
        step();

        // Clear together with we_n contention: recorded after the clear
        bus_a.drv_we_n_i    = 4'b0010;
        bus_a.drv_we_n_oe_i = 4'b0011;
        bus_a.clear_i       = 1'b1;
        step();
        check("clr_we_n",   32'(bus_a.bus_we_n_o), 32'h0);
        check("clr_count",  32'(bus_a.contention_count_o), 32'h1);
        check("clr_fvalid", 32'(bus_a.first_valid_o), 32'h1);
        check("clr_fgroup", 32'(bus_a.first_group_o), 32'h4);
        check("clr_faddr",  32'(bus_a.first_addr_o), 32'h0034);
        check("clr_foe",    32'(bus_a.first_oe_o), 32'h0);
        bus_a.drv_we_n_oe_i = 4'b0000;
        bus_a.clear_i       = 1'b0;
        step();
        bus_a.clear_i = 1'b1;
        step();
        check("clr_only_count",  32'(bus_a.contention_count_o), 32'h0);
        check("clr_only_fvalid", 32'(bus_a.first_valid_o), 32'h0);
        check("clr_only_fgroup", 32'(bus_a.first_group_o), 32'h0);
        bus_a.clear_i = 1'b0;

        // Small instance: 2-bit counter saturates, 0F & FF = 0F
        bus_b.drv_data_i    = {8'hFF, 8'h0F, 32'h0};
        bus_b.drv_data_oe_i = 6'b110000;
        for (int i = 0; i < 5; i++) begin
            step();
            check("sat_count", 32'(bus_b.contention_count_o), 32'(sat_exp[i]));
            check("sat_data",  32'(bus_b.bus_data_o), 32'h0F);
        end
        bus_b.drv_data_oe_i = 6'b000000;
        step();
        check("h0_float_after_cont", 32'(bus_b.bus_data_o), 32'hFF);
        check("h0_sat_stays",        32'(bus_b.contention_count_o), 32'h3);

        // HOLD_CYCLES=0: release floats on the very next edge
        bus_b.drv_data_i    = {8'h5A, 40'h0};
        bus_b.drv_data_oe_i = 6'b100000;
        step();
        check("h0_drive",   32'(bus_b.bus_data_o), 32'h5A);
        check("h0_valid",   32'(bus_b.bus_data_valid_o), 32'h1);
        bus_b.drv_data_oe_i = 6'b000000;
        step();
        check("h0_release", 32'(bus_b.bus_data_o), 32'hFF);
        check("h0_invalid", 32'(bus_b.bus_data_valid_o), 32'h0);

        // Async reset while data is held and contention has been recorded
        bus_a.drv_data_i    = {8'h00, 8'h00, 8'h77, 8'h77};
        bus_a.drv_data_oe_i = 4'b0011;
        step();
        check("pre_rst_count", 32'(bus_a.contention_count_o), 32'h1);
        bus_a.drv_data_oe_i = 4'b0000;
        step();
        check("pre_rst_hold",  32'(bus_a.bus_data_o), 32'h77);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_data",   32'(bus_a.bus_data_o), 32'hFF);
        check("mid_rst_valid",  32'(bus_a.bus_data_valid_o), 32'h0);
        check("mid_rst_count",  32'(bus_a.contention_count_o), 32'h0);
        check("mid_rst_fvalid", 32'(bus_a.first_valid_o), 32'h0);
        check("mid_rst_bcount", 32'(bus_b.contention_count_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_data", 32'(bus_a.bus_data_o), 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
